reg_file_mp: RTL and testbench
==============================

Name: reg_file_mp

Overview:
- Multi-port, parametrised register file for the lab2 datapath. Successor to the single-write, dual-read register file.
- NUM_RD combinational read ports and two synchronous write ports, with fixed write priority.
- Same-cycle write-to-read bypass and conflict detection.
- A sequential clear engine zeroes every register after reset or on request; `ready_o` indicates when the file is usable.

Parameters:
- NUM_REGS, 32, number of architectural registers; need not be a power of 2.
- ADR_WIDTH, $clog2(NUM_REGS), address width of every read/write address.
- DATA_WIDTH, 16, register width in bits.
- NUM_RD, 2, number of read ports; must be ≥1.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- reset_i  input  1  reset, synchronous, active-high.
- clear_i  input  1  request a full clear sweep; honoured only in READY.
- ra_i  input  NUM_RD*ADR_WIDTH  packed read addresses; port k = bits [k*ADR_WIDTH +: ADR_WIDTH].
- rd_o  output  NUM_RD*DATA_WIDTH  packed read data; port k = bits [k*DATA_WIDTH +: DATA_WIDTH]; combinational.
- wen0_i  input  1  write enable, port 0.
- wa0_i  input  ADR_WIDTH  write address, port 0.
- wd0_i  input  DATA_WIDTH  write data, port 0.
- wen1_i  input  1  write enable, port 1; has priority over port 0.
- wa1_i  input  ADR_WIDTH  write address, port 1.
- wd1_i  input  DATA_WIDTH  write data, port 1.
- ready_o  output  1  high when the file accepts writes and returns stored data.
- conflict_o  output  1  one-cycle pulse: previous cycle had both write ports on the same address.

Behaviour:
- State machine: two states, CLEAR and READY; clear pointer `ptr`, ADR_WIDTH bits.
- Reset: posedge with reset_i=1 → state=CLEAR, ptr=0, ready_o=0, conflict_o=0; register contents untouched that edge.
- Reset mid-sweep restarts the sweep at ptr=0.
- CLEAR state (reset_i=0):
  - Each edge: RF[ptr]<=0, ptr<=ptr+1.
  - On the edge where ptr==NUM_REGS-1, state<=READY and ready_o<=1.
  - Sweep length after reset deassert is exactly NUM_REGS edges.
- In CLEAR:
  - all rd_o ports read 0;
  - wen0_i, wen1_i and clear_i are ignored;
  - conflict_o stays 0.
- READY state:
  - clear_i=1 → state<=CLEAR, ptr<=0, ready_o<=0 next edge.
  - Writes presented in that same cycle are still performed.
- Writes (READY only): wenX_i=1 with waX_i<NUM_REGS → RF[waX_i]<=wdX_i at posedge. Out-of-range addresses (≥NUM_REGS) are dropped.
- Write collision: both enables high and wa0_i==wa1_i → only wd1_i is stored, and conflict_o<=1 for exactly the next cycle.
- conflict_o is 0 whenever the previous cycle had no collision.
- Reads: rd_o[k] = RF[ra_k], combinational, zero latency. Out-of-range address → 0.
- Bypass (READY only): if wen1_i and wa1_i==ra_k → rd_o[k]=wd1_i; else if wen0_i and wa0_i==ra_k → wd0_i; else stored value. Bypass applies only to in-range addresses.
- Width rules: no truncation or extension; data passes bit-exact.

Optional Feature:
- Macro: REG_FILE_MP_ZERO_REG_EN.
- Defined:
  - register 0 always reads 0, bypass included;
  - writes to address 0 are discarded and never cause conflict_o;
  - the clear sweep still visits address 0.
- Undefined: register 0 is an ordinary register.

Test Plan:
1. Reset, then hold idle. reset_i=1 for 1 edge, then 0; NUM_REGS=32 → ready_o=0 for 32 edges, 1 after the 32nd; all rd_o read 0 throughout.
2. Write, then read back. READY; write wen0 wa0=5 wd0=16'hBEEF, then ra port0=5 → rd_o port0=16'hBEEF next cycle. Same cycle as the write, ra port1=5 → bypass gives 16'hBEEF.
3. Collision. wen0 wa0=7 wd0=16'h1111 with wen1 wa1=7 wd1=16'h2222 → RF[7]=16'h2222; conflict_o=1 for exactly one cycle, then 0.
4. Clear request. clear_i=1 in READY with RF[3]=16'h00AA → ready_o=0 next cycle; writes during the sweep are ignored; after 32 edges ready_o=1 and RF[3] reads 0.
5. Reset mid-sweep. reset_i pulsed at sweep cycle 10 → ptr restarts; ready_o rises 32 edges after reset deassert, not earlier.
6. Out-of-range and zero register. NUM_REGS=24: write wa0=30 → no stored state change; ra=30 reads 0. With REG_FILE_MP_ZERO_REG_EN: write wa0=0 wd0=16'hFFFF → reg 0 reads 0, same cycle and after.

Source files
------------

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file with two prioritised write ports, bypass and clear sweep; REG_FILE_MP_ZERO_REG_EN hardwires reg 0 to zero
module reg_file_mp #(
  parameter int NUM_REGS   = 32,
  parameter int ADR_WIDTH  = $clog2(NUM_REGS),
  parameter int DATA_WIDTH = 16,
  parameter int NUM_RD     = 2
) (
  input  logic                         clk,
  input  logic                         reset_i,
  input  logic                         clear_i,
  input  logic [NUM_RD*ADR_WIDTH-1:0]  ra_i,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_o,
  input  logic                         wen0_i,
  input  logic [ADR_WIDTH-1:0]         wa0_i,
  input  logic [DATA_WIDTH-1:0]        wd0_i,
  input  logic                         wen1_i,
  input  logic [ADR_WIDTH-1:0]         wa1_i,
  input  logic [DATA_WIDTH-1:0]        wd1_i,
  output logic                         ready_o,
  output logic                         conflict_o
);
  typedef enum logic {S_CLEAR, S_READY} state_t;
`ifdef REG_FILE_MP_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif
  localparam logic [ADR_WIDTH:0]   NR   = (ADR_WIDTH+1)'(NUM_REGS);
  localparam logic [ADR_WIDTH-1:0] LAST = ADR_WIDTH'(NUM_REGS-1);
  state_t state, state_nxt;
  logic [ADR_WIDTH-1:0] ptr, ptr_nxt;
  logic [DATA_WIDTH-1:0] rf [NUM_REGS];
  logic rdy, w0, w1, coll;
  function automatic logic valid(input logic [ADR_WIDTH-1:0] a);
    return ({1'b0, a} < NR) && !(ZR && a == '0);
  endfunction
  always_comb begin
    rdy       = state == S_READY;
    w0        = rdy && wen0_i && valid(wa0_i);
    w1        = rdy && wen1_i && valid(wa1_i);
    coll      = rdy && wen0_i && wen1_i && wa0_i == wa1_i && !(ZR && wa0_i == '0);
    state_nxt = rdy ? (clear_i ? S_CLEAR : S_READY) : (ptr == LAST ? S_READY : S_CLEAR);
    ptr_nxt   = (rdy || ptr == LAST) ? '0 : ptr + ADR_WIDTH'(1);
  end
  always_ff @(posedge clk) begin
    if (reset_i) begin
      state      <= S_CLEAR;
      ptr        <= '0;
      conflict_o <= 1'b0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      conflict_o <= coll;
    end
  end
  // port 1 is written last so it wins a same-address collision
  always_ff @(posedge clk) begin
    if (!reset_i) begin
      if (!rdy) rf[ptr] <= '0;
      else begin
        if (w0) rf[wa0_i] <= wd0_i;
        if (w1) rf[wa1_i] <= wd1_i;
      end
    end
  end
  assign ready_o = rdy;
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADR_WIDTH-1:0] ra;
    assign ra = ra_i[k*ADR_WIDTH +: ADR_WIDTH];
    assign rd_o[k*DATA_WIDTH +: DATA_WIDTH] = (!rdy || !valid(ra)) ? '0 :
                                              (wen1_i && wa1_i == ra) ? wd1_i :
                                              (wen0_i && wa0_i == ra) ? wd0_i : rf[ra];
  end
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: directed and randomized checks of reg_file_mp against a behavioural model
module tb_reg_file_mp;
  localparam int N  = 24;
  localparam int AW = 5;
  localparam int DW = 16;
  localparam int NR = 2;
`ifdef REG_FILE_MP_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif
  logic clk = 0, reset_i, clear_i, wen0_i, wen1_i, ready_o, conflict_o;
  logic [NR*AW-1:0] ra_i;
  logic [NR*DW-1:0] rd_o;
  logic [AW-1:0] wa0_i, wa1_i;
  logic [DW-1:0] wd0_i, wd1_i;
  int n_cmp = 0, n_bad = 0;
  logic [DW-1:0] mem [N];
  bit m_rdy = 0, m_conf = 0;
  int left = N;
  reg_file_mp #(.NUM_REGS(N), .ADR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR)) dut (
    .clk(clk), .reset_i(reset_i), .clear_i(clear_i), .ra_i(ra_i), .rd_o(rd_o),
    .wen0_i(wen0_i), .wa0_i(wa0_i), .wd0_i(wd0_i),
    .wen1_i(wen1_i), .wa1_i(wa1_i), .wd1_i(wd1_i),
    .ready_o(ready_o), .conflict_o(conflict_o));
  always #5 clk = ~clk;
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic bit wr_ok(input int a);
    return a < N && !(ZR && a == 0);
  endfunction
  function automatic logic [DW-1:0] exp_rd(input int a);
    if (!m_rdy || !wr_ok(a)) return '0;
    if (wen1_i && int'(wa1_i) == a) return wd1_i;
    if (wen0_i && int'(wa0_i) == a) return wd0_i;
    return mem[a];
  endfunction
  function automatic logic [DW-1:0] rdp(input int k);
    return rd_o[k*DW +: DW];
  endfunction
  task automatic upd();
    if (reset_i) begin
      m_rdy = 0; left = N; m_conf = 0;
    end else if (!m_rdy) begin
      mem[N-left] = '0;
      left--;
      m_rdy = left == 0;
      m_conf = 0;
    end else begin
      if (wen0_i && wr_ok(wa0_i)) mem[wa0_i] = wd0_i;
      if (wen1_i && wr_ok(wa1_i)) mem[wa1_i] = wd1_i;
      m_conf = wen0_i && wen1_i && wa0_i == wa1_i && !(ZR && wa0_i == 0);
      if (clear_i) begin m_rdy = 0; left = N; end
    end
  endtask
  task automatic cyc();
    #1;
    for (int k = 0; k < NR; k++)
      check($sformatf("rd%0d@%0d", k, ra_i[k*AW +: AW]), rdp(k), exp_rd(int'(ra_i[k*AW +: AW])));
    check("ready", ready_o, m_rdy);
    check("conflict", conflict_o, m_conf);
    @(posedge clk);
    upd();
    #1;
  endtask
  task automatic idle();
    clear_i = 0; wen0_i = 0; wen1_i = 0;
  endtask
  task automatic sweep(input string tag);
    int n = 0;
    while (!ready_o && n < 200) begin cyc(); n++; end
    check(tag, n, N);
  endtask
  initial begin
    idle(); reset_i = 1; ra_i = '0; wa0_i = 0; wa1_i = 0; wd0_i = 0; wd1_i = 0;
    @(posedge clk); upd(); #1;
    check("rst_ready", ready_o, 0);
    check("rst_conflict", conflict_o, 0);
    reset_i = 0;
    sweep("t1_sweep_len");
    wen0_i = 1; wa0_i = 5; wd0_i = 16'hBEEF; ra_i[AW +: AW] = 5; ra_i[0 +: AW] = 9;
    #1 check("t2_bypass", rdp(1), 16'hBEEF);
    cyc();
    idle(); ra_i[0 +: AW] = 5;
    #1 check("t2_read", rdp(0), 16'hBEEF);
    cyc();
    wen0_i = 1; wa0_i = 7; wd0_i = 16'h1111; wen1_i = 1; wa1_i = 7; wd1_i = 16'h2222; ra_i[0 +: AW] = 7;
    #1 check("t3_bypass", rdp(0), 16'h2222);
    cyc();
    idle();
    #1 check("t3_conf_hi", conflict_o, 1);
    check("t3_stored", rdp(0), 16'h2222);
    cyc();
    check("t3_conf_lo", conflict_o, 0);
    wen0_i = 1; wa0_i = 3; wd0_i = 16'h00AA;
    cyc();
    idle(); clear_i = 1;
    cyc();
    clear_i = 0;
    check("t4_ready_lo", ready_o, 0);
    wen0_i = 1; wa0_i = 3; wd0_i = 16'h1234; wen1_i = 1; wa1_i = 4; wd1_i = 16'h5678; clear_i = 1;
    sweep("t4_sweep_len");
    idle(); ra_i[0 +: AW] = 3; ra_i[AW +: AW] = 4;
    #1 check("t4_rd3", rdp(0), 0);
    check("t4_rd4", rdp(1), 0);
    clear_i = 1;
    cyc();
    clear_i = 0;
    repeat (10) cyc();
    reset_i = 1;
    cyc();
    reset_i = 0;
    sweep("t5_sweep_len");
    wen0_i = 1; wa0_i = 30; wd0_i = 16'hDEAD; ra_i[0 +: AW] = 30;
    #1 check("t6_oor_same", rdp(0), 0);
    cyc();
    idle();
    #1 check("t6_oor_after", rdp(0), 0);
    cyc();
    wen0_i = 1; wa0_i = 0; wd0_i = 16'hFFFF; ra_i[0 +: AW] = 0;
    #1 check("t6_r0_same", rdp(0), ZR ? 16'h0 : 16'hFFFF);
    cyc();
    idle();
    #1 check("t6_r0_after", rdp(0), ZR ? 16'h0 : 16'hFFFF);
    cyc();
    for (int i = 0; i < 500; i++) begin
      reset_i = $urandom % 150 == 0;
      clear_i = $urandom % 40 == 0;
      wen0_i = 1'($urandom); wen1_i = 1'($urandom);
      wa0_i = AW'($urandom_range(0, 31)); wa1_i = AW'($urandom_range(0, 31));
      if ($urandom % 5 == 0) wa1_i = wa0_i;
      if (wa1_i == wa0_i && wa0_i >= N) wa1_i = AW'($urandom_range(0, N-1));
      wd0_i = DW'($urandom); wd1_i = DW'($urandom);
      for (int k = 0; k < NR; k++) begin
        int s = $urandom % 4;
        ra_i[k*AW +: AW] = s == 0 ? wa0_i : s == 1 ? wa1_i : AW'($urandom_range(0, 31));
      end
      cyc();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
